// File: rtl/rcu_rst_seq_if.sv
// Signal bundle between the RCU reset sequencer and its requesters/consumers.
// The master side raises requests and controls; the slave side is the sequencer.
interface rcu_rst_seq_if #(
    parameter int NUM_DOM = 4
);
    logic               ext_rst_req;
    logic               wdt_rst_req;
    logic               sw_rst_req;
    logic               pll_en;
    logic               pll_lock;
    logic               cause_clr;
    logic [NUM_DOM-1:0] rst_n;
    logic               clk_sel;
    logic               done;
    logic               lock_err;
    logic [3:0]         rst_cause;
    logic [2:0]         state;

    modport master (
        output ext_rst_req, wdt_rst_req, sw_rst_req, pll_en, pll_lock, cause_clr,
        input  rst_n, clk_sel, done, lock_err, rst_cause, state
    );

    modport slave (
        input  ext_rst_req, wdt_rst_req, sw_rst_req, pll_en, pll_lock, cause_clr,
        output rst_n, clk_sel, done, lock_err, rst_cause, state
    );
endinterface

// File: rtl/rcu_rst_seq.sv
// RCU reset/clock bring-up sequencer: hold resets, optional PLL lock and clock switch,
// staged domain release, sticky reset-cause and lock-error status.
module rcu_rst_seq #(
    parameter int NUM_DOM   = 4,
    parameter int CNT_WIDTH = 16,
    parameter int HOLD_CYC  = 16,
    parameter int LOCK_TMO  = 1024,
    parameter int SW_CYC    = 4,
    parameter int STAGE_CYC = 8
) (
    input  logic         clk,
    input  logic         rst,
    rcu_rst_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_ASSERT   = 3'd0,
        S_PLL_WAIT = 3'd1,
        S_CLK_SW   = 3'd2,
        S_RELEASE  = 3'd3,
        S_RUN      = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(LOCK_TMO - 1);
    localparam logic [CNT_WIDTH-1:0] SW_LAST   = CNT_WIDTH'(SW_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] REL_LAST  = CNT_WIDTH'((NUM_DOM - 1) * STAGE_CYC);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [NUM_DOM-1:0]   rst_n_q, rst_n_nxt;
    logic                 clk_sel_q, clk_sel_nxt;
    logic                 lock_err_q, lock_err_nxt;
    logic [3:0]           cause_q, cause_nxt;
    logic                 lock_q;

    logic req;
    logic lock_ok;
    logic lock_lost;
    logic lock_err_set;
    logic [3:0] cause_set;

    assign req       = bus.ext_rst_req | bus.wdt_rst_req | bus.sw_rst_req;
    // Lock must be seen on two consecutive cycles to count, and be missing for two to be lost.
    assign lock_ok   = bus.pll_lock & lock_q;
    assign lock_lost = clk_sel_q & ~bus.pll_lock & ~lock_q;
    assign cause_set = {bus.sw_rst_req, bus.wdt_rst_req, bus.ext_rst_req, 1'b0};

    // State register plus all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_ASSERT;
            cnt        <= '0;
            rst_n_q    <= '0;
            clk_sel_q  <= 1'b0;
            lock_err_q <= 1'b0;
            cause_q    <= 4'b0001;
            lock_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rst_n_q    <= rst_n_nxt;
            clk_sel_q  <= clk_sel_nxt;
            lock_err_q <= lock_err_nxt;
            cause_q    <= cause_nxt;
            lock_q     <= bus.pll_lock;
        end
    end

    // Next-state logic; a request overrides every other transition.
    // NOTE: each combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_ASSERT:   if (cnt == HOLD_LAST) state_nxt = bus.pll_en ? S_PLL_WAIT : S_RELEASE;
            S_PLL_WAIT: begin
                if (lock_ok)              state_nxt = S_CLK_SW;
                else if (cnt == TMO_LAST) state_nxt = S_RELEASE;
            end
            S_CLK_SW:   if (cnt == SW_LAST)  state_nxt = S_RELEASE;
            S_RELEASE:  if (cnt == REL_LAST) state_nxt = S_RUN;
            S_RUN:      if (lock_lost)       state_nxt = S_ASSERT;
            default:    state_nxt = S_ASSERT;
        endcase
        if (req) state_nxt = S_ASSERT;
    end

    // Next values of counter and registered outputs.
    always_comb begin
        cnt_nxt      = cnt + CNT_WIDTH'(1);
        rst_n_nxt    = rst_n_q;
        clk_sel_nxt  = clk_sel_q;
        lock_err_set = 1'b0;

        if (req || state_nxt != state || state == S_RUN) cnt_nxt = '0;

        if (state == S_RELEASE) begin
            for (int k = 0; k < NUM_DOM; k++) begin
                if (cnt == CNT_WIDTH'(k * STAGE_CYC)) rst_n_nxt[k] = 1'b1;
            end
        end

        if (state == S_PLL_WAIT && state_nxt == S_CLK_SW) clk_sel_nxt = 1'b1;

        if (!req) begin
            lock_err_set = (state == S_PLL_WAIT && !lock_ok && cnt == TMO_LAST) ||
                           (state == S_RUN && lock_lost);
        end

        if (state_nxt == S_ASSERT) begin
            rst_n_nxt   = '0;
            clk_sel_nxt = 1'b0;
        end

        // A source active alongside the clear keeps its bit.
        lock_err_nxt = bus.cause_clr ? lock_err_set : (lock_err_q | lock_err_set);
        cause_nxt    = bus.cause_clr ? cause_set    : (cause_q | cause_set);
    end

    assign bus.rst_n     = rst_n_q;
    assign bus.clk_sel   = clk_sel_q;
    assign bus.done      = (state == S_RUN);
    assign bus.lock_err  = lock_err_q;
    assign bus.rst_cause = cause_q;
    assign bus.state     = state;
endmodule
